// File: rtl/multdiv_seq.sv
// Sequential multiply/divide unit: radix-4 Booth multiply, restoring divide.
// Start pulses restart at any time; results land with a one-cycle ready pulse.
module multdiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             ctrl_SIGNED,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_result_hi,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int AW = WIDTH + 4;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic              sgn, a_top, b_top, qm1;
   logic [WIDTH-1:0]  a_reg, lo, rem, dvs;
   logic signed [AW-1:0] acc;
   logic [WIDTH-1:0]  res_lo, res_hi;
   logic              exc;

   logic              start;
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic signed [AW-1:0] mcand, addend, sum;
   logic [WIDTH-1:0]  prod_hi;
   logic              mul_exc;
   logic [WIDTH:0]    shifted;
   logic              take;
   logic [WIDTH-1:0]  rem_nx, quo, rmd;
   logic              div_zero, div_ovf;

   assign start = ctrl_MULT | ctrl_DIV;

   // Operand magnitudes captured at start for the divide path
   always_comb begin
      mag_a = data_operandA;
      mag_b = data_operandB;
      if (ctrl_SIGNED && data_operandA[WIDTH-1]) mag_a = -data_operandA;
      if (ctrl_SIGNED && data_operandB[WIDTH-1]) mag_b = -data_operandB;
   end

   // Booth digit selection, partial-product add and final correction
   always_comb begin
      mcand  = {{(AW-WIDTH){sgn & a_top}}, a_reg};
      addend = '0;
      case ({lo[1:0], qm1})
         3'b001, 3'b010: addend = mcand;
         3'b011:         addend = mcand <<< 1;
         3'b100:         addend = -(mcand <<< 1);
         3'b101, 3'b110: addend = -mcand;
         default:        addend = '0;
      endcase
      sum = acc + addend;
      // Booth treats B as signed; an unsigned B with its top bit set
      // needs A added back at weight 2^WIDTH.
      prod_hi = acc[WIDTH-1:0] + ((!sgn && b_top) ? a_reg : '0);
      if (sgn) mul_exc = (prod_hi != {WIDTH{lo[WIDTH-1]}});
      else     mul_exc = (prod_hi != '0);
   end

   // Restoring divide step and sign fix-up of the final magnitudes
   always_comb begin
      shifted  = {rem, lo[WIDTH-1]};
      take     = (shifted >= {1'b0, dvs});
      rem_nx   = take ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
      quo      = (sgn && (a_top ^ b_top)) ? -lo : lo;
      rmd      = (sgn && a_top) ? -rem : rem;
      div_zero = (dvs == '0);
      div_ovf  = sgn && a_top && (a_reg[WIDTH-2:0] == '0)
                 && b_top && (dvs == WIDTH'(1));
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state: a start always wins, multiply before divide
   always_comb begin
      state_nx = state;
      if (ctrl_MULT)     state_nx = MUL;
      else if (ctrl_DIV) state_nx = DIV;
      else begin
         unique case (state)
            IDLE: state_nx = IDLE;
            MUL:  if (cnt == MUL_LAST) state_nx = DONE;
            DIV:  if (div_zero || cnt == DIV_LAST) state_nx = DONE;
            DONE: state_nx = IDLE;
         endcase
      end
   end

   // Status outputs decoded from state
   always_comb begin
      busy           = (state == MUL) || (state == DIV);
      data_resultRDY = (state == DONE);
   end

   // Datapath: latch on start, iterate, then register the results
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0; sgn <= 1'b0; a_top <= 1'b0; b_top <= 1'b0;
         qm1 <= 1'b0; a_reg <= '0; lo <= '0; rem <= '0; dvs <= '0;
         acc <= '0; res_lo <= '0; res_hi <= '0; exc <= 1'b0;
      end else if (start) begin
         cnt   <= '0;
         sgn   <= ctrl_SIGNED;
         a_top <= data_operandA[WIDTH-1];
         b_top <= data_operandB[WIDTH-1];
         a_reg <= data_operandA;
         acc   <= '0;
         qm1   <= 1'b0;
         rem   <= '0;
         dvs   <= mag_b;
         lo    <= ctrl_MULT ? data_operandB : mag_a;
      end else begin
         case (state)
            MUL: begin
               if (cnt != MUL_LAST) begin
                  acc <= sum >>> 2;
                  lo  <= {sum[1:0], lo[WIDTH-1:2]};
                  qm1 <= lo[1];
                  cnt <= cnt + CW'(1);
               end else begin
                  res_lo <= lo;
                  res_hi <= prod_hi;
                  exc    <= mul_exc;
               end
            end
            DIV: begin
               if (div_zero) begin
                  res_lo <= '0;
                  res_hi <= a_reg;
                  exc    <= 1'b1;
               end else if (cnt != DIV_LAST) begin
                  rem <= rem_nx;
                  lo  <= {lo[WIDTH-2:0], take};
                  cnt <= cnt + CW'(1);
               end else begin
                  res_lo <= quo;
                  res_hi <= rmd;
                  exc    <= div_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign data_result    = res_lo;
   assign data_result_hi = res_hi;
   assign data_exception = exc;

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: directed plan cases, abort/reset checks and
// randomized operands checked against an arithmetic reference model.
module tb_multdiv_seq;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         ctrl_MULT, ctrl_DIV, ctrl_SIGNED;
   logic [W-1:0] data_operandA, data_operandB;
   logic [W-1:0] data_result, data_result_hi;
   logic         data_exception, data_resultRDY, busy;

   int vectors     = 0;
   int miscompares = 0;

   multdiv_seq #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .ctrl_SIGNED    (ctrl_SIGNED),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_result_hi (data_result_hi),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic m, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] lo,
                                 output logic [W-1:0] hi,
                                 output logic exc);
      logic [2*W-1:0] p;
      longint sa, sb, q, r;
      if (m) begin
         if (s) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
         else   p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         lo  = p[W-1:0];
         hi  = p[2*W-1:W];
         exc = s ? (hi != {W{lo[W-1]}}) : (hi != '0);
      end else if (b == '0) begin
         lo = '0; hi = a; exc = 1'b1;
      end else begin
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
         end
         q   = sa / sb;
         r   = sa % sb;
         lo  = q[W-1:0];
         hi  = r[W-1:0];
         exc = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      end
   endfunction

   task automatic pulse(input logic m, input logic d, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      ctrl_MULT = m; ctrl_DIV = d; ctrl_SIGNED = s;
      data_operandA = a; data_operandB = b;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      ctrl_SIGNED = 1'($urandom);
      data_operandA = $urandom; data_operandB = $urandom;
   endtask

   task automatic wait_rdy(output int lat, output int busy_bad);
      lat = -1; busy_bad = 0;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         @(posedge clock); #1;
         if (data_resultRDY) lat = i;
         else if (!busy) busy_bad++;
      end
   endtask

   task automatic count_rdy(input int n, output int seen);
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         if (data_resultRDY) seen++;
      end
   endtask

   task automatic run(input string tag, input logic m, input logic d,
                      input logic s, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] elo,
                      input logic [W-1:0] ehi, input logic eexc,
                      input int elat);
      int lat, bb;
      pulse(m, d, s, a, b);
      wait_rdy(lat, bb);
      chk({tag, " latency"}, W'(lat), W'(elat));
      chk({tag, " busy_wait"}, W'(bb), '0);
      chk({tag, " busy_rdy"}, W'(busy), '0);
      chk({tag, " result"}, data_result, elo);
      chk({tag, " result_hi"}, data_result_hi, ehi);
      chk({tag, " exception"}, W'(data_exception), W'(eexc));
   endtask

   initial begin
      int seen, lat, bb;
      logic [W-1:0] a, b, elo, ehi;
      logic eexc, m, s;

      reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; ctrl_SIGNED = 1'b0;
      data_operandA = '0; data_operandB = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst result", data_result, '0);
      chk("rst result_hi", data_result_hi, '0);
      chk("rst exception", W'(data_exception), '0);
      chk("rst rdy", W'(data_resultRDY), '0);
      chk("rst busy", W'(busy), '0);
      @(negedge clock);
      reset = 1'b0;

      run("umul ffff", 1, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF,
          32'hFFFE_0001, 32'h0, 0, 17);
      run("smul -7x6", 1, 0, 1, 32'hFFFF_FFF9, 32'd6,
          32'hFFFF_FFD6, 32'hFFFF_FFFF, 0, 17);
      run("umul ovf", 1, 0, 0, 32'h8000_0000, 32'd2,
          32'h0, 32'h1, 1, 17);
      run("sdiv -17/5", 0, 1, 1, 32'hFFFF_FFEF, 32'd5,
          32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, 33);
      run("udiv 100/7", 0, 1, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33);
      run("div0", 0, 1, 0, 32'd1234, 32'd0, 32'd0, 32'd1234, 1, 1);
      run("sdiv ovf", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 32'h0, 1, 33);

      count_rdy(3, seen);
      chk("hold rdy", W'(seen), '0);
      chk("hold result", data_result, 32'h8000_0000);
      chk("hold exception", W'(data_exception), 32'd1);
      chk("hold busy", W'(busy), '0);

      pulse(0, 1, 0, 32'd1000, 32'd3);
      count_rdy(9, seen);
      chk("abort early rdy", W'(seen), '0);
      pulse(1, 0, 0, 32'd3, 32'd4);
      wait_rdy(lat, bb);
      chk("abort latency", W'(lat), 32'd17);
      chk("abort result", data_result, 32'd12);
      chk("abort result_hi", data_result_hi, '0);
      count_rdy(30, seen);
      chk("abort extra rdy", W'(seen), '0);

      run("mul+div", 1, 1, 0, 32'd5, 32'd6, 32'd30, 32'd0, 0, 17);

      pulse(1, 0, 1, 32'hFFFF_FFF9, 32'd6);
      count_rdy(4, seen);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("midrst result", data_result, '0);
      chk("midrst result_hi", data_result_hi, '0);
      chk("midrst exception", W'(data_exception), '0);
      chk("midrst busy", W'(busy), '0);
      chk("midrst rdy", W'(data_resultRDY), '0);
      @(negedge clock);
      reset = 1'b0;
      count_rdy(25, seen);
      chk("midrst no rdy", W'(seen), '0);

      for (int mode = 0; mode < 4; mode++) begin
         m = (mode < 2);
         s = mode[0];
         for (int i = 0; i < 100; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
            if (!m && $urandom_range(0, 19) == 0) b = '0;
            if (s && $urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            model(m, s, a, b, elo, ehi, eexc);
            run(m ? (s ? "rnd smul" : "rnd umul") : (s ? "rnd sdiv" : "rnd udiv"),
                m, !m, s, a, b, elo, ehi, eexc,
                m ? 17 : ((b == '0) ? 1 : 33));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

- Parametrised, sequential multiply/divide unit; next generation of the combinational 32-bit Wallace multiplier.
- Multiply: iterative radix-4 Booth. Divide: restoring division.
- Adds signed/unsigned mode, a divide path, overflow and divide-by-zero exceptions, and a start/ready handshake.
- Sits beside the ALU; owns its operands from start until the ready pulse.

## Interface
- WIDTH, 32, operand and result width; must be even and ≥ 4.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- ctrl_SIGNED  input  1  1 = two's-complement operands; sampled with start.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled with start.
- data_operandB  input  WIDTH  multiplier / divisor; sampled with start.
- data_result  output  WIDTH  low product / quotient.
- data_result_hi  output  WIDTH  high product / remainder.
- data_exception  output  1  overflow or divide-by-zero; valid with ready.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  operation in progress.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start priority: ctrl_MULT beats ctrl_DIV when both are high.
- Starts are accepted in any state. A start while busy aborts the current operation and restarts with the new operands; no ready pulse is issued for the aborted operation.
- On accepted start:
  - Latch operands and ctrl_SIGNED.
  - Clear the iteration counter.
  - Go to MUL or DIV.
- MUL:
  - Operand sign-extended by 2 bits when signed, zero-extended when unsigned.
  - Booth step per cycle; WIDTH/2 steps; full 2·WIDTH product.
  - data_result = product[WIDTH-1:0], data_result_hi = product[2·WIDTH-1:WIDTH].
  - Exception, signed: high half is not the sign-extension of bit WIDTH-1.
  - Exception, unsigned: high half is nonzero.
- DIV:
  - Signed: divide magnitudes, then fix signs. Quotient truncates toward zero; remainder takes the dividend's sign.
  - One restoring step per cycle; WIDTH steps.
  - Divisor 0: skip iteration, go straight to DONE. result = 0, result_hi = dividend, exception = 1.
  - Signed MIN / −1: result = MIN, result_hi = 0, exception = 1.
- DONE:
  - Drive results, pulse data_resultRDY for one cycle, return to IDLE.
  - Outputs hold their last values until the next DONE or reset.
- Operand inputs are don't-care except in the start cycle.

## Timing
- T = rising edge that samples the start.
- data_resultRDY is high during the cycle following these edges:
  - Multiply: edge T + WIDTH/2 + 1 (17 for WIDTH = 32).
  - Divide: edge T + WIDTH + 1 (33).
  - Divide by zero: edge T + 1.
- data_result, data_result_hi and data_exception update on the same edge that raises data_resultRDY.
- busy:
  - High from edge T until the edge that raises data_resultRDY.
  - Low during the ready cycle.
- Back-to-back: a start in the ready cycle is accepted. The next result follows the normal latency measured from that edge.
- Reset (any time, including mid-operation): at the next edge, state = IDLE, all outputs = 0, counter = 0, and no ready pulse is issued.

## Test plan
- WIDTH = 32, unsigned multiply 0x0000FFFF × 0x0000FFFF → ready after exactly 17 cycles; result 0xFFFE0001, result_hi 0, exception 0.
- Signed multiply −7 × 6 → result 0xFFFFFFD6, result_hi 0xFFFFFFFF, exception 0. Unsigned 0x80000000 × 2 → result 0, result_hi 1, exception 1.
- Divides, each ready after 33 cycles:
  - Signed −17 ÷ 5 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFE (−2), exception 0.
  - Unsigned 100 ÷ 7 → 14 rem 2.
- Divide 1234 ÷ 0 → ready 1 cycle after start; result 0, result_hi 1234, exception 1. Signed 0x80000000 ÷ −1 → result 0x80000000, exception 1.
- Abort and collision:
  - ctrl_DIV at T, then ctrl_MULT 3 × 4 at T+10 → exactly one ready pulse, at T+10+17, with result 12.
  - ctrl_MULT and ctrl_DIV together → multiply performed.
- Reset at T+5 of a multiply → outputs 0 and busy 0 next cycle; no ready pulse. Randomised regression: 100 random operand pairs in each mode checked against a reference model.
